// File: rtl/rbfu_writeback_pkg.sv
// Shared constants and opcode encoding for the butterfly write-back path.
// Opcodes travel with each butterfly so the write strobes follow the delayed op.
package rbfu_writeback_pkg;

    localparam int DATA_W      = 12;
    localparam int ADDR_W      = 8;
    localparam int BFU_LATENCY = 5;

    typedef enum logic [1:0] {
        OP_NTT  = 2'b00,
        OP_INTT = 2'b01,
        OP_PWM0 = 2'b10,
        OP_PWM1 = 2'b11
    } op_e;

    // PWM1 leaves Dout2 at a constant zero, so its second port stays idle.
    function automatic logic needs_wr2(op_e op);
        return op != OP_PWM1;
    endfunction

endpackage

// File: rtl/rbfu_writeback_if.sv
// Issue, butterfly-result and memory-write bundle of the write-back block.
// The sequencer side is master, the write-back controller is slave.
interface rbfu_writeback_if
    import rbfu_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
) ();

    logic                  flush;
    logic                  issue_valid;
    logic                  issue_last;
    logic [1:0]            issue_op;
    logic [ADDR_WIDTH-1:0] issue_addr1;
    logic [ADDR_WIDTH-1:0] issue_addr2;
    logic [DATA_WIDTH-1:0] bfu_dout1;
    logic [DATA_WIDTH-1:0] bfu_dout2;
    logic                  wr_en1;
    logic                  wr_en2;
    logic [ADDR_WIDTH-1:0] wr_addr1;
    logic [ADDR_WIDTH-1:0] wr_addr2;
    logic [DATA_WIDTH-1:0] wr_data1;
    logic [DATA_WIDTH-1:0] wr_data2;
    logic                  busy;
    logic                  stage_done;
    logic                  addr_conflict;

    modport master (
        output flush, issue_valid, issue_last, issue_op,
        output issue_addr1, issue_addr2, bfu_dout1, bfu_dout2,
        input  wr_en1, wr_en2, wr_addr1, wr_addr2,
        input  wr_data1, wr_data2, busy, stage_done, addr_conflict
    );

    modport slave (
        input  flush, issue_valid, issue_last, issue_op,
        input  issue_addr1, issue_addr2, bfu_dout1, bfu_dout2,
        output wr_en1, wr_en2, wr_addr1, wr_addr2,
        output wr_data1, wr_data2, busy, stage_done, addr_conflict
    );

endinterface

// File: rtl/wb_tag_pipe.sv
// Fixed-depth delay line for packed write-back tags.
// A synchronous clear wipes every stage, dropping all in-flight tags.
module wb_tag_pipe #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign dout = stg[DEPTH-1];

endmodule

// File: rtl/rbfu_writeback.sv
// Butterfly write-back controller: delays issue tags by the butterfly
// latency, then registers both memory write ports and tracks completion.
module rbfu_writeback
    import rbfu_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int BFU_LAT    = BFU_LATENCY
) (
    input  logic            clk,
    input  logic            rst,
    rbfu_writeback_if.slave bus
);

    localparam int CW = $clog2(BFU_LAT + 2);
    localparam int TW = 2 * ADDR_WIDTH + 4;
    localparam logic [CW-1:0] CNT_MAX = CW'(BFU_LAT + 1);

    logic                  clr;
    logic [TW-1:0]         tag_in;
    logic [TW-1:0]         tag_out;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_wr2;
    logic                  m_hit;
    op_e                   m_op;
    logic [ADDR_WIDTH-1:0] m_addr1;
    logic [ADDR_WIDTH-1:0] m_addr2;

    logic [CW-1:0]         cnt;
    logic                  wr_en1;
    logic                  wr_en2;
    logic                  stage_done;
    logic                  addr_conflict;
    logic [ADDR_WIDTH-1:0] wr_addr1;
    logic [ADDR_WIDTH-1:0] wr_addr2;
    logic [DATA_WIDTH-1:0] wr_data1;
    logic [DATA_WIDTH-1:0] wr_data2;

    assign clr    = rst | bus.flush;
    assign tag_in = {bus.issue_valid, bus.issue_last, bus.issue_op,
                     bus.issue_addr1, bus.issue_addr2};

    wb_tag_pipe #(
        .DEPTH (BFU_LAT),
        .WIDTH (TW)
    ) u_tag_pipe (
        .clk  (clk),
        .clr  (clr),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign m_valid = tag_out[TW-1];
    assign m_last  = tag_out[TW-2];
    assign m_op    = op_e'(tag_out[TW-3 -: 2]);
    assign m_addr1 = tag_out[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign m_addr2 = tag_out[ADDR_WIDTH-1:0];
    assign m_wr2   = m_valid & needs_wr2(m_op);

    // Conflict is judged on the write pair being registered this edge.
    assign m_hit   = m_valid & m_wr2 & (m_addr1 == m_addr2);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en1        <= 1'b0;
            wr_en2        <= 1'b0;
            stage_done    <= 1'b0;
            addr_conflict <= 1'b0;
            wr_addr1      <= '0;
            wr_addr2      <= '0;
            wr_data1      <= '0;
            wr_data2      <= '0;
            cnt           <= '0;
        end else if (bus.flush) begin
            wr_en1        <= 1'b0;
            wr_en2        <= 1'b0;
            stage_done    <= 1'b0;
            addr_conflict <= 1'b0;
            cnt           <= '0;
        end else begin
            wr_en1     <= m_valid;
            wr_en2     <= m_wr2;
            stage_done <= m_valid & m_last;
            if (m_valid) begin
                wr_addr1 <= m_addr1;
                wr_addr2 <= m_addr2;
                wr_data1 <= bus.bfu_dout1;
                wr_data2 <= bus.bfu_dout2;
            end
            if (m_hit) begin
                addr_conflict <= 1'b1;
            end
            // An op stays counted until its write strobe has been seen.
            unique case ({bus.issue_valid, wr_en1})
                2'b10: if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                2'b01: if (cnt != '0) cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.wr_en1        = wr_en1;
    assign bus.wr_en2        = wr_en2;
    assign bus.wr_addr1      = wr_addr1;
    assign bus.wr_addr2      = wr_addr2;
    assign bus.wr_data1      = wr_data1;
    assign bus.wr_data2      = wr_data2;
    assign bus.stage_done    = stage_done;
    assign bus.addr_conflict = addr_conflict;
    assign bus.busy          = (cnt != '0);

endmodule

// File: tb/tb_rbfu_writeback.sv
// Randomized and directed bench for rbfu_writeback against an
// issue-history reference model.
module tb_rbfu_writeback;
    import rbfu_writeback_pkg::*;

    localparam int LAT = BFU_LATENCY;
    localparam int N   = 1024;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rbfu_writeback_if bus ();

    rbfu_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;

    bit         acc [N];
    bit         lst [N];
    bit         clr [N];
    logic [1:0] opa [N];
    logic [7:0] a1a [N];
    logic [7:0] a2a [N];

    logic        e_en1, e_en2, e_sd, e_conf, e_busy;
    logic [7:0]  e_a1, e_a2;
    logic [11:0] e_d1, e_d2;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     tag, n, got, exp);
        end
    endtask

    // Tag issued at edge i is written at edge i+LAT unless a clear hits
    // any edge in between; it counts as busy until edge i+LAT+1.
    function automatic bit alive(int i, int upto);
        for (int k = i + 1; k <= upto; k++) begin
            if (clr[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(bit r, bit f, bit v, bit l, logic [1:0] op,
                        logic [7:0] x1, logic [7:0] x2,
                        logic [11:0] d1, logic [11:0] d2);
        bit wr;
        int i;
        int cnt;
        rst             = r;
        bus.flush       = f;
        bus.issue_valid = v;
        bus.issue_last  = l;
        bus.issue_op    = op;
        bus.issue_addr1 = x1;
        bus.issue_addr2 = x2;
        bus.bfu_dout1   = d1;
        bus.bfu_dout2   = d2;
        @(posedge clk);
        acc[n] = v & ~r & ~f;
        lst[n] = l;
        clr[n] = r | f;
        opa[n] = op;
        a1a[n] = x1;
        a2a[n] = x2;
        i  = n - LAT;
        wr = (i >= 0) && acc[i] && alive(i, n);
        if (r) begin
            {e_en1, e_en2, e_sd, e_conf} = '0;
            e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
        end else if (f) begin
            {e_en1, e_en2, e_sd, e_conf} = '0;
        end else begin
            e_en1 = wr;
            e_en2 = 1'b0;
            e_sd  = 1'b0;
            if (wr) begin
                e_en2 = (opa[i] != 2'b11);
                e_sd  = lst[i];
                e_a1  = a1a[i];
                e_a2  = a2a[i];
                e_d1  = d1;
                e_d2  = d2;
                if (e_en2 && a1a[i] == a2a[i]) e_conf = 1'b1;
            end
        end
        cnt = 0;
        for (int j = (n > LAT ? n - LAT : 0); j <= n; j++) begin
            if (acc[j] && alive(j, n)) cnt++;
        end
        e_busy = (cnt != 0);
        @(negedge clk);
        check("wr_en1", 32'(bus.wr_en1), 32'(e_en1));
        check("wr_en2", 32'(bus.wr_en2), 32'(e_en2));
        check("stage_done", 32'(bus.stage_done), 32'(e_sd));
        check("busy", 32'(bus.busy), 32'(e_busy));
        check("addr_conflict", 32'(bus.addr_conflict), 32'(e_conf));
        check("wr_addr1", 32'(bus.wr_addr1), 32'(e_a1));
        check("wr_addr2", 32'(bus.wr_addr2), 32'(e_a2));
        check("wr_data1", 32'(bus.wr_data1), 32'(e_d1));
        check("wr_data2", 32'(bus.wr_data2), 32'(e_d2));
        n++;
    endtask

    task automatic idle(int k, logic [11:0] d1, logic [11:0] d2);
        for (int j = 0; j < k; j++) begin
            step(0, 0, 0, 0, 2'b00, 8'h00, 8'h00, d1, d2);
        end
    endtask

    initial begin
        logic [1:0] mix [4];
        int         pct;
        mix[0] = 2'b00;
        mix[1] = 2'b10;
        mix[2] = 2'b11;
        mix[3] = 2'b01;

        // reset held with issue_valid high
        for (int j = 0; j < 3; j++) begin
            step(1, 0, 1, 1, 2'b00, 8'h11, 8'h11, 12'h0, 12'h0);
        end
        idle(1, 12'h0, 12'h0);

        // single NTT
        step(0, 0, 1, 0, 2'b00, 8'h10, 8'h90, 12'h123, 12'h456);
        idle(8, 12'h123, 12'h456);

        // PWM1 stream, last flagged on the eighth
        for (int j = 0; j < 8; j++) begin
            step(0, 0, 1, j == 7, 2'b11, 8'(j), 8'(8'h40 + j),
                 12'($urandom_range(0, 4095)), 12'h000);
        end
        idle(8, 12'h5a5, 12'h000);

        // mixed opcodes every cycle
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 1, j == 3, mix[j], 8'(8'h20 + j), 8'(8'hA0 + j),
                 12'($urandom_range(0, 4095)),
                 12'($urandom_range(0, 4095)));
        end
        idle(8, 12'h321, 12'h654);

        // flush mid-stage
        for (int j = 0; j < 3; j++) begin
            step(0, 0, 1, j == 2, 2'b01, 8'(8'h30 + j), 8'(8'hB0 + j),
                 12'h111, 12'h222);
        end
        step(0, 1, 1, 1, 2'b00, 8'h33, 8'hB3, 12'h111, 12'h222);
        idle(8, 12'h777, 12'h888);

        // address conflict, sticky until flush
        step(0, 0, 1, 0, 2'b00, 8'h22, 8'h22, 12'h0, 12'h0);
        idle(9, 12'hABC, 12'hDEF);
        step(0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 12'h0, 12'h0);
        idle(2, 12'h0, 12'h0);

        // random traffic
        for (int j = 0; j < 400; j++) begin
            pct = $urandom_range(0, 99);
            step(pct == 0, pct >= 1 && pct <= 3,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 15,
                 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 7)),
                 8'($urandom_range(0, 7)),
                 12'($urandom_range(0, 4095)),
                 12'($urandom_range(0, 4095)));
        end
        idle(8, 12'h0, 12'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
